// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap stream generator: FSM states, field widths
// and the padding predicate used by the address pipeline.
package ifmap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_NEXT_SET,
      ST_NEXT_ITER,
      ST_NEXT_BATCH,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int unsigned ROW_TAG_W_DEF = 4;
   localparam int unsigned COL_TAG_W_DEF = 5;
   localparam int unsigned U_W           = 2;
   localparam int unsigned PAD_W         = 2;
   localparam int unsigned N_W           = 3;
   localparam int unsigned E_W           = 5;
   localparam int unsigned Q_W           = 3;
   localparam int unsigned R_W           = 3;
   localparam int unsigned S_W           = 4;

   // True when the (row, padded column) position falls in the zero border.
   function automatic logic is_pad(input int unsigned row, input int unsigned col,
                                   input int unsigned hw, input int unsigned pad);
      return (row < pad) || (row >= hw + pad) || (col < pad) || (col >= hw + pad);
   endfunction

endpackage

// File: rtl/ifmap_addr_pipe.sv
// Stage-1 GLB address/padding compute plus a GLB_RD_LAT-deep tag delay line.
// Every register holds while stall_i is high.
module ifmap_addr_pipe
   import ifmap_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned HW_W       = 8,
   parameter int unsigned ROW_TAG_W  = ROW_TAG_W_DEF,
   parameter int unsigned COL_TAG_W  = COL_TAG_W_DEF,
   parameter int unsigned GLB_RD_LAT = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           stall_i,
   input  logic                           slot_vld_i,
   input  logic [ADDR_W-1:0]              base_i,
   input  logic [R_W-1:0]                 set_i,
   input  logic [Q_W-1:0]                 chan_i,
   input  logic [HW_W-1:0]                row_i,
   input  logic [S_W-1:0]                 col_i,
   input  logic [HW_W-1:0]                woff_i,
   input  logic [Q_W-1:0]                 layer_q_i,
   input  logic [HW_W-1:0]                layer_hw_i,
   input  logic [PAD_W-1:0]               layer_pad_i,
   output logic                           re_c_o,
   output logic [ADDR_W-1:0]              ra_o,
   output logic                           tag_valid_o,
   output logic                           tag_zero_o,
   output logic [ROW_TAG_W+COL_TAG_W-1:0] tag_o,
   output logic                           busy_c_o
);

   localparam int unsigned TAG_W = ROW_TAG_W + COL_TAG_W;

   logic [31:0]       wcol_c;
   logic [31:0]       chan_c;
   logic [31:0]       addr_c;
   logic              pad_c;
   logic [TAG_W-1:0]  tag_c;

   logic              s1_vld_q;
   logic              s1_pad_q;
   logic [ADDR_W-1:0] s1_ra_q;
   logic [TAG_W-1:0]  s1_tag_q;

   logic              dl_vld_q  [GLB_RD_LAT];
   logic              dl_zero_q [GLB_RD_LAT];
   logic [TAG_W-1:0]  dl_tag_q  [GLB_RD_LAT];

   // Full-width address; padding slots may wrap, their address is never used.
   always_comb begin
      wcol_c = 32'(col_i) + 32'(woff_i);
      pad_c  = is_pad(32'(row_i), wcol_c, 32'(layer_hw_i), 32'(layer_pad_i));
      chan_c = 32'(set_i) * 32'(layer_q_i) + 32'(chan_i);
      addr_c = 32'(base_i)
             + chan_c * 32'(layer_hw_i) * 32'(layer_hw_i)
             + (32'(row_i) - 32'(layer_pad_i)) * 32'(layer_hw_i)
             + wcol_c - 32'(layer_pad_i);
      tag_c  = {ROW_TAG_W'(32'(set_i) + 32'd1), COL_TAG_W'(32'(row_i) + 32'd1)};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_vld_q <= 1'b0;
         s1_pad_q <= 1'b0;
         s1_ra_q  <= '0;
         s1_tag_q <= '0;
         for (int i = 0; i < GLB_RD_LAT; i++) begin
            dl_vld_q[i]  <= 1'b0;
            dl_zero_q[i] <= 1'b0;
            dl_tag_q[i]  <= '0;
         end
      end else if (!stall_i) begin
         s1_vld_q <= slot_vld_i;
         s1_pad_q <= slot_vld_i & pad_c;
         if (slot_vld_i) begin
            s1_ra_q  <= ADDR_W'(addr_c);
            s1_tag_q <= tag_c;
         end
         dl_vld_q[0]  <= s1_vld_q;
         dl_zero_q[0] <= s1_pad_q;
         dl_tag_q[0]  <= s1_tag_q;
         for (int i = 1; i < GLB_RD_LAT; i++) begin
            dl_vld_q[i]  <= dl_vld_q[i-1];
            dl_zero_q[i] <= dl_zero_q[i-1];
            dl_tag_q[i]  <= dl_tag_q[i-1];
         end
      end
   end

   // The held slot issues its read only in a non-stalled cycle, so exactly once.
   always_comb begin
      re_c_o   = s1_vld_q & ~s1_pad_q & ~stall_i;
      busy_c_o = s1_vld_q;
      for (int i = 0; i < GLB_RD_LAT; i++) busy_c_o = busy_c_o | dl_vld_q[i];
   end

   assign ra_o        = s1_ra_q;
   assign tag_valid_o = dl_vld_q[GLB_RD_LAT-1];
   assign tag_zero_o  = dl_zero_q[GLB_RD_LAT-1];
   assign tag_o       = dl_tag_q[GLB_RD_LAT-1];

endmodule

// File: rtl/ifmap_stream_gen.sv
// Ifmap GLB load controller: walks batch/pass/set/row/channel/column slots.
// Optional saturating performance counters under IFMAP_PERF_CNT_EN.
module ifmap_stream_gen
   import ifmap_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned HW_W       = 8,
   parameter int unsigned ROW_TAG_W  = ROW_TAG_W_DEF,
   parameter int unsigned COL_TAG_W  = COL_TAG_W_DEF,
   parameter int unsigned GLB_RD_LAT = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_load_start,
   input  logic                           i_stall,
   input  logic [ADDR_W-1:0]              i_ifmap_base,
   input  logic [ADDR_W-1:0]              i_batch_stride,
   input  logic [HW_W-1:0]                i_layer_HW,
   input  logic [U_W-1:0]                 i_layer_U,
   input  logic [PAD_W-1:0]               i_layer_PAD,
   input  logic [N_W-1:0]                 i_layer_n,
   input  logic [E_W-1:0]                 i_layer_e,
   input  logic [Q_W-1:0]                 i_layer_q,
   input  logic [R_W-1:0]                 i_layer_r,
   input  logic [S_W-1:0]                 i_layer_s,
   output logic                           o_ifmap_glb_re,
   output logic [ADDR_W-1:0]              o_ifmap_glb_ra,
   output logic                           o_tag_valid,
   output logic                           o_tag_zero,
   output logic [ROW_TAG_W+COL_TAG_W-1:0] o_ifmap_tag,
   output logic                           o_busy,
   output logic                           o_load_done
`ifdef IFMAP_PERF_CNT_EN
   ,
   output logic [31:0]                    o_perf_reads,
   output logic [31:0]                    o_perf_zeros,
   output logic [31:0]                    o_perf_stalls
`endif
);

   state_e            state_q, state_d;
   logic [S_W-1:0]    w_q, w_d;
   logic [Q_W-1:0]    c_q, c_d;
   logic [HW_W-1:0]   h_q, h_d;
   logic [R_W-1:0]    set_q, set_d;
   logic [E_W-1:0]    iter_q, iter_d;
   logic [N_W-1:0]    batch_q, batch_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [31:0]       h_rows_c;
   logic              w_last_c, c_last_c, h_last_c;
   logic [HW_W-1:0]   woff_c;
   logic              pipe_busy_c;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         w_q      <= '0;
         c_q      <= '0;
         h_q      <= '0;
         set_q    <= '0;
         iter_q   <= '0;
         batch_q  <= '0;
         base_q   <= '0;
         stride_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         c_q      <= c_d;
         h_q      <= h_d;
         set_q    <= set_d;
         iter_q   <= iter_d;
         batch_q  <= batch_d;
         base_q   <= base_d;
         stride_q <= stride_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Slot walk W -> C -> H inside LOAD; set/iter/batch stepped in their own states.
   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      c_d      = c_q;
      h_d      = h_q;
      set_d    = set_q;
      iter_d   = iter_q;
      batch_d  = batch_q;
      base_d   = base_q;
      stride_d = stride_q;

      h_rows_c = (32'(i_layer_e) - 32'd1) * 32'(i_layer_U) + 32'(i_layer_s);
      w_last_c = (32'(w_q) + 32'd1) >= 32'(i_layer_s);
      c_last_c = (32'(c_q) + 32'd1) >= 32'(i_layer_q);
      h_last_c = (32'(h_q) + 32'd1) >= h_rows_c;
      woff_c   = HW_W'(32'(iter_q) * 32'(i_layer_U));

      if (!i_stall || state_q == ST_IDLE || state_q == ST_DONE) begin
         case (state_q)
            ST_IDLE: begin
               if (i_load_start) begin
                  state_d  = ST_LOAD;
                  base_d   = i_ifmap_base;
                  stride_d = i_batch_stride;
                  w_d      = '0;
                  c_d      = '0;
                  h_d      = '0;
                  set_d    = '0;
                  iter_d   = '0;
                  batch_d  = '0;
               end
            end
            ST_LOAD: begin
               w_d = w_q + S_W'(1);
               if (w_last_c) begin
                  w_d = '0;
                  c_d = c_q + Q_W'(1);
                  if (c_last_c) begin
                     c_d = '0;
                     h_d = h_q + HW_W'(1);
                     if (h_last_c) begin
                        h_d     = '0;
                        state_d = ST_NEXT_SET;
                     end
                  end
               end
            end
            ST_NEXT_SET: begin
               if ((32'(set_q) + 32'd1) < 32'(i_layer_r)) begin
                  set_d   = set_q + R_W'(1);
                  state_d = ST_LOAD;
               end else begin
                  set_d   = '0;
                  state_d = ST_NEXT_ITER;
               end
            end
            ST_NEXT_ITER: begin
               if ((32'(iter_q) + 32'd1) < 32'(i_layer_e)) begin
                  iter_d  = iter_q + E_W'(1);
                  state_d = ST_LOAD;
               end else begin
                  iter_d  = '0;
                  state_d = ST_NEXT_BATCH;
               end
            end
            ST_NEXT_BATCH: begin
               if ((32'(batch_q) + 32'd1) < 32'(i_layer_n)) begin
                  batch_d = batch_q + N_W'(1);
                  base_d  = base_q + stride_q;
                  state_d = ST_LOAD;
               end else begin
                  batch_d = '0;
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!pipe_busy_c) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   ifmap_addr_pipe #(
      .ADDR_W     (ADDR_W),
      .HW_W       (HW_W),
      .ROW_TAG_W  (ROW_TAG_W),
      .COL_TAG_W  (COL_TAG_W),
      .GLB_RD_LAT (GLB_RD_LAT)
   ) u_addr_pipe (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .stall_i     (i_stall),
      .slot_vld_i  (state_q == ST_LOAD),
      .base_i      (base_q),
      .set_i       (set_q),
      .chan_i      (c_q),
      .row_i       (h_q),
      .col_i       (w_q),
      .woff_i      (woff_c),
      .layer_q_i   (i_layer_q),
      .layer_hw_i  (i_layer_HW),
      .layer_pad_i (i_layer_PAD),
      .re_c_o      (o_ifmap_glb_re),
      .ra_o        (o_ifmap_glb_ra),
      .tag_valid_o (o_tag_valid),
      .tag_zero_o  (o_tag_zero),
      .tag_o       (o_ifmap_tag),
      .busy_c_o    (pipe_busy_c)
   );

   assign o_busy      = busy_q;
   assign o_load_done = done_q;

`ifdef IFMAP_PERF_CNT_EN
   logic [31:0] perf_reads_q;
   logic [31:0] perf_zeros_q;
   logic [31:0] perf_stalls_q;
   logic        start_acc_c;

   assign start_acc_c = (state_q == ST_IDLE) && i_load_start;

   // Saturating event counters, cleared when a pass is accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst || start_acc_c) begin
         perf_reads_q  <= '0;
         perf_zeros_q  <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (o_ifmap_glb_re && (perf_reads_q != '1))
            perf_reads_q <= perf_reads_q + 32'd1;
         if (o_tag_valid && o_tag_zero && !i_stall && (perf_zeros_q != '1))
            perf_zeros_q <= perf_zeros_q + 32'd1;
         if (busy_q && i_stall && (perf_stalls_q != '1))
            perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign o_perf_reads  = perf_reads_q;
   assign o_perf_zeros  = perf_zeros_q;
   assign o_perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_ifmap_stream_gen.sv
// Bench for ifmap_stream_gen: table-driven passes, random configurations with
// random stall, and hand-written timing/reset sequences against a loop-nest model.
module tb_ifmap_stream_gen;

   logic        i_clk;
   logic        i_rst;
   logic        i_load_start;
   logic        i_stall = 1'b0;
   logic [15:0] i_ifmap_base;
   logic [15:0] i_batch_stride;
   logic [7:0]  i_layer_HW;
   logic [1:0]  i_layer_U;
   logic [1:0]  i_layer_PAD;
   logic [2:0]  i_layer_n;
   logic [4:0]  i_layer_e;
   logic [2:0]  i_layer_q;
   logic [2:0]  i_layer_r;
   logic [3:0]  i_layer_s;
   logic        o_ifmap_glb_re;
   logic [15:0] o_ifmap_glb_ra;
   logic        o_tag_valid;
   logic        o_tag_zero;
   logic [8:0]  o_ifmap_tag;
   logic        o_busy;
   logic        o_load_done;

   typedef struct {
      int hw, u, pad, n, e, q, r, s;
      int base, stride, pct;
      int exp_slots, exp_zeros, exp_first_ra, exp_first_tag;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int unsigned stall_pct = 0;
   logic [15:0] got_ra[$], got_tag[$], exp_ra[$], exp_tag[$];

   ifmap_stream_gen dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_load_start   (i_load_start),
      .i_stall        (i_stall),
      .i_ifmap_base   (i_ifmap_base),
      .i_batch_stride (i_batch_stride),
      .i_layer_HW     (i_layer_HW),
      .i_layer_U      (i_layer_U),
      .i_layer_PAD    (i_layer_PAD),
      .i_layer_n      (i_layer_n),
      .i_layer_e      (i_layer_e),
      .i_layer_q      (i_layer_q),
      .i_layer_r      (i_layer_r),
      .i_layer_s      (i_layer_s),
      .o_ifmap_glb_re (o_ifmap_glb_re),
      .o_ifmap_glb_ra (o_ifmap_glb_ra),
      .o_tag_valid    (o_tag_valid),
      .o_tag_zero     (o_tag_zero),
      .o_ifmap_tag    (o_ifmap_tag),
      .o_busy         (o_busy),
      .o_load_done    (o_load_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      #1 i_stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
   end

   // Collect the issued read stream and the consumed tag stream.
   always @(negedge i_clk) begin
      if (o_ifmap_glb_re) got_ra.push_back(o_ifmap_glb_ra);
      if (o_tag_valid && !i_stall) got_tag.push_back(16'({o_tag_zero, o_ifmap_tag}));
      if (o_load_done) done_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_seq(input string name, input logic [15:0] act[$], input logic [15:0] exp[$]);
      int idx = -1;
      checks++;
      for (int i = 0; i < exp.size() && idx < 0; i++)
         if (i >= act.size() || act[i] !== exp[i]) idx = i;
      if (idx < 0 && act.size() != exp.size()) idx = exp.size();
      if (idx >= 0) begin
         failures++;
         $display("FAIL %s diff at %0d: actual len=%0d val=0x%0h expected len=%0d val=0x%0h",
                  name, idx, act.size(), (idx < act.size()) ? act[idx] : 16'h0,
                  exp.size(), (idx < exp.size()) ? exp[idx] : 16'h0);
      end
   endtask

   // Reference: plain loop nest over the slot order with the address/padding rules.
   task automatic build_model(input vec_t v);
      int rows, wc, ad;
      logic pad;
      exp_ra.delete();
      exp_tag.delete();
      rows = (v.e - 1) * v.u + v.s;
      for (int b = 0; b < v.n; b++)
         for (int it = 0; it < v.e; it++)
            for (int st = 0; st < v.r; st++)
               for (int h = 0; h < rows; h++)
                  for (int ch = 0; ch < v.q; ch++)
                     for (int w = 0; w < v.s; w++) begin
                        wc  = w + it * v.u;
                        pad = (h < v.pad) || (h >= v.hw + v.pad) || (wc < v.pad) || (wc >= v.hw + v.pad);
                        exp_tag.push_back(16'({pad, 4'(st + 1), 5'(h + 1)}));
                        if (!pad) begin
                           ad = v.base + b * v.stride + (st * v.q + ch) * v.hw * v.hw
                              + (h - v.pad) * v.hw + wc - v.pad;
                           exp_ra.push_back(16'(ad));
                        end
                     end
   endtask

   task automatic apply_cfg(input vec_t v);
      i_layer_HW     = 8'(v.hw);
      i_layer_U      = 2'(v.u);
      i_layer_PAD    = 2'(v.pad);
      i_layer_n      = 3'(v.n);
      i_layer_e      = 5'(v.e);
      i_layer_q      = 3'(v.q);
      i_layer_r      = 3'(v.r);
      i_layer_s      = 4'(v.s);
      i_ifmap_base   = 16'(v.base);
      i_batch_stride = 16'(v.stride);
   endtask

   task automatic run_pass(input vec_t v, input string name);
      int cyc = 0;
      apply_cfg(v);
      build_model(v);
      @(posedge i_clk);
      #2;
      got_ra.delete();
      got_tag.delete();
      done_cnt     = 0;
      stall_pct    = int'(v.pct);
      i_load_start = 1'b1;
      @(posedge i_clk);
      #2 i_load_start = 1'b0;
      while (done_cnt == 0 && cyc < 20000) begin
         @(negedge i_clk);
         cyc++;
      end
      stall_pct = 0;
      repeat (4) @(negedge i_clk);
      check({name, "_done_pulses"}, done_cnt, 1);
      check_seq({name, "_ra_seq"}, got_ra, exp_ra);
      check_seq({name, "_tag_seq"}, got_tag, exp_tag);
   endtask

   vec_t tbl[7];
   vec_t rv;
   int   zeros, cyc;

   initial begin
      //           hw u pad n e q r s  base    stride  pct slots zeros first_ra first_tag
      tbl[0] = '{4, 1, 0, 1, 2, 1, 1, 3, 'h40,   0,      0,  24,   0,   'h40,    'h021};
      tbl[1] = '{4, 1, 1, 1, 4, 1, 1, 3, 'h200,  0,      0,  72,   32,  'h200,   'h221};
      tbl[2] = '{4, 1, 0, 1, 1, 2, 2, 2, 'h1000, 0,      0,  16,   0,   'h1000,  'h021};
      tbl[3] = '{4, 1, 0, 2, 1, 1, 1, 1, 'h300,  'h100,  0,  2,    0,   'h300,   'h021};
      tbl[4] = '{3, 1, 0, 1, 1, 1, 1, 1, 'h10,   0,      0,  1,    0,   'h10,    'h021};
      tbl[5] = '{4, 1, 1, 1, 4, 1, 1, 3, 'h200,  0,      30, 72,   32,  'h200,   'h221};
      tbl[6] = '{3, 2, 2, 1, 2, 1, 1, 2, 'h80,   0,      0,  16,   12,  'h80,    'h221};

      i_rst        = 1'b1;
      i_load_start = 1'b0;
      apply_cfg(tbl[0]);
      repeat (2) @(negedge i_clk);
      check("reset_outputs", {o_ifmap_glb_re, o_ifmap_glb_ra, o_tag_valid, o_tag_zero,
                              o_ifmap_tag, o_busy, o_load_done}, 0);
      @(posedge i_clk);
      #2 i_rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_pass(tbl[i], $sformatf("vec%0d", i));
         zeros = 0;
         foreach (got_tag[k]) if (got_tag[k][9]) zeros++;
         check($sformatf("vec%0d_slots", i), got_tag.size(), tbl[i].exp_slots);
         check($sformatf("vec%0d_zeros", i), zeros, tbl[i].exp_zeros);
         check($sformatf("vec%0d_first_ra", i), (got_ra.size() > 0) ? got_ra[0] : 16'hdead, tbl[i].exp_first_ra);
         check($sformatf("vec%0d_first_tag", i), (got_tag.size() > 0) ? got_tag[0] : 16'hdead, tbl[i].exp_first_tag);
      end

      // Second channel set starts HW*HW*q words further on with row tag 2.
      run_pass(tbl[2], "set1");
      check("set1_first_ra", (got_ra.size() > 8) ? got_ra[8] : 16'hdead, 'h1020);
      check("set1_first_tag", (got_tag.size() > 8) ? got_tag[8] : 16'hdead, 'h041);

      // Batch 1 reads offset by the batch stride.
      run_pass(tbl[3], "batch1");
      check("batch1_ra", (got_ra.size() > 1) ? got_ra[1] : 16'hdead, 'h400);

      for (int k = 0; k < 8; k++) begin
         rv.hw = int'($urandom_range(6, 2));  rv.u = int'($urandom_range(3, 1));
         rv.pad = int'($urandom_range(2, 0)); rv.n = int'($urandom_range(2, 1));
         rv.e = int'($urandom_range(3, 1));   rv.q = int'($urandom_range(3, 1));
         rv.r = int'($urandom_range(2, 1));   rv.s = int'($urandom_range(4, 1));
         rv.base = int'($urandom_range(16'hffff, 0));
         rv.stride = int'($urandom_range(16'hffff, 0));
         rv.pct = (k % 4 == 3) ? 0 : 30;
         rv.exp_slots = 0; rv.exp_zeros = 0; rv.exp_first_ra = 0; rv.exp_first_tag = 0;
         run_pass(rv, $sformatf("rand%0d", k));
      end

      // Pipeline latency, done/busy alignment, start during DONE ignored.
      apply_cfg(tbl[0]);
      @(posedge i_clk);
      #2 i_load_start = 1'b1;
      @(posedge i_clk);
      #2 i_load_start = 1'b0;
      @(negedge i_clk);
      check("busy_rise", {o_busy, o_ifmap_glb_re}, 2'b10);
      @(negedge i_clk);
      check("first_read", {o_ifmap_glb_re, o_ifmap_glb_ra}, {1'b1, 16'h0040});
      @(negedge i_clk);
      check("first_tag_timing", {o_tag_valid, o_tag_zero, o_ifmap_tag}, 11'h421);
      cyc = 0;
      while (!o_load_done && cyc < 20000) begin
         @(negedge i_clk);
         cyc++;
      end
      check("done_busy_low", {o_load_done, o_busy}, 2'b10);
      i_load_start = 1'b1;
      @(posedge i_clk);
      #2 i_load_start = 1'b0;
      @(negedge i_clk);
      check("done_single_cycle", {o_load_done, o_busy}, 0);
      repeat (3) @(negedge i_clk);
      check("start_in_done_ignored", o_busy, 0);

      // Reset in the middle of LOAD aborts without a done pulse.
      apply_cfg(tbl[1]);
      @(posedge i_clk);
      #2 i_load_start = 1'b1;
      @(posedge i_clk);
      #2 i_load_start = 1'b0;
      repeat (6) @(posedge i_clk);
      #2;
      check("busy_before_reset", o_busy, 1);
      i_rst    = 1'b1;
      done_cnt = 0;
      @(posedge i_clk);
      #2 i_rst = 1'b0;
      @(negedge i_clk);
      check("midreset_outputs", {o_ifmap_glb_re, o_ifmap_glb_ra, o_tag_valid, o_tag_zero,
                                 o_ifmap_tag, o_busy, o_load_done}, 0);
      repeat (30) @(negedge i_clk);
      check("midreset_no_done", {o_busy, 31'(done_cnt)}, 0);
      run_pass(tbl[0], "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
